// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared owner enum, byte-enable width and default widths for mem_arbiter
package mips_mem_pkg;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int BEW = 4;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DS} owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational tie-break between fetch and data ports
// Ports: i_if_elig/i_ds_elig eligibility, i_last_ds last grant was data, o_gnt_if/o_gnt_ds one-hot grant
// Build option: MEM_ARB_RR_EN selects round-robin ties, otherwise data port wins ties
module mem_arb_pick
  import mips_mem_pkg::*;
(
  input  logic i_if_elig,
  input  logic i_ds_elig,
  input  logic i_last_ds,
  output logic o_gnt_if,
  output logic o_gnt_ds
);
`ifdef MEM_ARB_RR_EN
  // on a tie the port not granted last goes
  assign o_gnt_ds = i_ds_elig & (~i_if_elig | ~i_last_ds);
`else
  logic w_unused;
  assign w_unused = i_last_ds;
  assign o_gnt_ds = i_ds_elig;
`endif
  assign o_gnt_if = i_if_elig & ~o_gnt_ds;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port sync memory between fetch (if_*) and data (ds_*) ports
// Ports: clk, rst (async active-low); if_req/if_addr -> if_rdata/if_done/if_stall;
//        ds_req/ds_we/ds_be/ds_addr/ds_wdata -> ds_rdata/ds_done/ds_stall;
//        mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory (one cycle after mem_en)
// Build option: MEM_ARB_RR_EN enables round-robin tie-break, default is data-port priority
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req,
  input  logic [AW-1:0]  if_addr,
  output logic [DW-1:0]  if_rdata,
  output logic           if_done,
  output logic           if_stall,
  input  logic           ds_req,
  input  logic           ds_we,
  input  logic [BEW-1:0] ds_be,
  input  logic [AW-1:0]  ds_addr,
  input  logic [DW-1:0]  ds_wdata,
  output logic [DW-1:0]  ds_rdata,
  output logic           ds_done,
  output logic           ds_stall,
  output logic           mem_en,
  output logic [BEW-1:0] mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata
);
  owner_t r_owner, w_owner_nx;
  logic w_if_elig, w_ds_elig, w_gnt_if, w_gnt_ds, w_last_ds;
  // a port in its done cycle still holds req, so it must not be re-issued
  assign w_if_elig = if_req & (r_owner != OWN_IF);
  assign w_ds_elig = ds_req & (r_owner != OWN_DS);
  mem_arb_pick u_pick (
    .i_if_elig(w_if_elig),
    .i_ds_elig(w_ds_elig),
    .i_last_ds(w_last_ds),
    .o_gnt_if (w_gnt_if),
    .o_gnt_ds (w_gnt_ds)
  );
`ifdef MEM_ARB_RR_EN
  logic r_last_ds;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_last_ds <= 1'b0;
    else if (w_gnt_if | w_gnt_ds) r_last_ds <= w_gnt_ds;
  assign w_last_ds = r_last_ds;
`else
  assign w_last_ds = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_owner <= OWN_NONE;
    else r_owner <= w_owner_nx;
  always_comb begin
    w_owner_nx = w_gnt_ds ? OWN_DS : w_gnt_if ? OWN_IF : OWN_NONE;
    mem_en     = rst & (w_gnt_if | w_gnt_ds);
    mem_we     = (rst & w_gnt_ds & ds_we) ? ds_be : '0;
    mem_addr   = w_gnt_ds ? ds_addr : if_addr;
    mem_wdata  = ds_wdata;
  end
  assign if_done  = (r_owner == OWN_IF);
  assign ds_done  = (r_owner == OWN_DS);
  assign if_stall = if_req & ~if_done;
  assign ds_stall = ds_req & ~ds_done;
  assign if_rdata = mem_rdata;
  assign ds_rdata = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard of expected dones checked by a monitor
module tb_mem_arbiter;
  logic        clk = 0, rst = 0;
  logic        if_req = 0, ds_req = 0, ds_we = 0;
  logic [31:0] if_addr = 0, ds_addr = 0, ds_wdata = 0;
  logic [3:0]  ds_be = 0;
  logic [31:0] if_rdata, ds_rdata, mem_addr, mem_wdata, mem_rdata = 0;
  logic        if_done, if_stall, ds_done, ds_stall, mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem [256];
  int n_chk = 0, n_pass = 0;
  typedef struct {bit is_ds; bit has_data; logic [31:0] data;} exp_t;
  exp_t sb[$];
  exp_t m_e;
  logic [31:0] bb_exp [4] = '{32'hC0DE_0040, 32'hC0DE_0044, 32'hC0DE_0048, 32'hC0DE_004C};

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .ds_req(ds_req), .ds_we(ds_we), .ds_be(ds_be), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
    .ds_rdata(ds_rdata), .ds_done(ds_done), .ds_stall(ds_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) begin
    for (int b = 0; b < 4; b++) if (mem_we[b]) mem[mem_addr[9:2]][8*b+:8] <= mem_wdata[8*b+:8];
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic push(input bit d, input bit h, input logic [31:0] v);
    sb.push_back('{is_ds: d, has_data: h, data: v});
  endtask

  always @(negedge clk) if (if_done || ds_done) begin
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_done: if_done=%b ds_done=%b with nothing outstanding", if_done, ds_done);
    end else begin
      m_e = sb.pop_front();
      chk("done_port", {30'b0, if_done, ds_done}, m_e.is_ds ? 32'd1 : 32'd2);
      if (m_e.has_data) chk(m_e.is_ds ? "ds_rdata" : "if_rdata", m_e.is_ds ? ds_rdata : if_rdata, m_e.data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 0;
    mem[8'h04] = 32'h1234_5678;
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'hC0DE_0040 + 4 * i;
    // reset holds outputs quiet even with requests asserted
    @(negedge clk);
    if_req = 1; ds_req = 1;
    #1 chk("rst_mem_en", mem_en, 0); chk("rst_mem_we", mem_we, 0);
    chk("rst_if_done", if_done, 0); chk("rst_ds_done", ds_done, 0);
    @(negedge clk);
    if_req = 0; ds_req = 0; rst = 1;
    @(negedge clk);
    #1 chk("idle_mem_en", mem_en, 0);
    // single write 0x80, be=0011
    @(negedge clk);
    ds_req = 1; ds_we = 1; ds_be = 4'b0011; ds_addr = 32'h80; ds_wdata = 32'hDEAD_BEEF;
    #1 chk("wr_mem_en", mem_en, 1); chk("wr_mem_we", mem_we, 4'b0011);
    chk("wr_mem_addr", mem_addr, 32'h80); chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr_ds_stall", ds_stall, 1);
    push(1, 0, 0);
    @(negedge clk);
    #1 chk("wr_done_stall", ds_stall, 0); chk("wr_nodup", mem_en, 0);
    ds_req = 0;
    // read back 0x80
    @(negedge clk);
    ds_req = 1; ds_we = 0; ds_be = 0;
    #1 chk("rd_mem_we", mem_we, 0); chk("rd_mem_addr", mem_addr, 32'h80);
    push(1, 1, 32'h0000_BEEF);
    @(negedge clk);
    ds_req = 0;
    // single fetch 0x40
    @(negedge clk);
    if_req = 1; if_addr = 32'h40;
    #1 chk("f_mem_en", mem_en, 1); chk("f_mem_addr", mem_addr, 32'h40);
    chk("f_mem_we", mem_we, 0); chk("f_if_stall", if_stall, 1);
    push(0, 1, 32'hC0DE_0040);
    @(negedge clk);
    #1 chk("f_done_stall", if_stall, 0); chk("f_nodup", mem_en, 0);
    if_req = 0;
    // contention: last grant was fetch, so data wins in either build
    @(negedge clk);
    if_req = 1; if_addr = 32'h44; ds_req = 1; ds_addr = 32'h10;
    #1 chk("c_first_addr", mem_addr, 32'h10); chk("c_if_stall_n", if_stall, 1);
    push(1, 1, 32'h1234_5678); push(0, 1, 32'hC0DE_0044);
    @(negedge clk);
    #1 chk("c_second_en", mem_en, 1); chk("c_second_addr", mem_addr, 32'h44);
    chk("c_if_stall_n1", if_stall, 1); chk("c_ds_stall_n1", ds_stall, 0);
    ds_req = 0;
    @(negedge clk);
    #1 chk("c_if_stall_n2", if_stall, 0);
    if_req = 0;
    // both held for six cycles: strict alternation DS, IF, ...
    @(negedge clk);
    if_req = 1; if_addr = 32'h48; ds_req = 1; ds_addr = 32'h10;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 5) ds_req = 0;
      #1 chk("alt_en", mem_en, 1); chk("alt_addr", mem_addr, (i % 2) ? 32'h48 : 32'h10);
      push(i % 2 == 0, 1, (i % 2) ? 32'hC0DE_0048 : 32'h1234_5678);
    end
    @(negedge clk);
    #1 chk("alt_end_en", mem_en, 0);
    if_req = 0;
    // back-to-back fetches stepping by 4
    @(negedge clk);
    if_req = 1; if_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      #1 chk("bb_en", mem_en, 1); chk("bb_addr", mem_addr, 32'h40 + 4 * k);
      push(0, 1, bb_exp[k]);
      @(negedge clk);
      if (k < 3) if_addr = if_addr + 4; else if_req = 0;
      #1 chk("bb_nodup", mem_en, 0);
      @(negedge clk);
    end
    // reset while a data read is in flight
    ds_req = 1; ds_we = 0; ds_addr = 32'h10;
    #1 chk("rm_issue_en", mem_en, 1);
    #2 rst = 0;
    #1 chk("rm_forced_en", mem_en, 0);
    @(negedge clk);
    @(negedge clk);
    ds_req = 0; rst = 1;
    #1 chk("rm_ds_done", ds_done, 0); chk("rm_mem_en", mem_en, 0);
    @(negedge clk);
    #1 chk("rm_ds_done2", ds_done, 0); chk("rm_if_done2", if_done, 0);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
